// File: rtl/flow_zigzag.sv
// Double-buffered 8x8 raster-to-zigzag reorder stage on the flow valid/sob/eob/sof interface.
// The writer fills one 64-entry bank while the reader drains the other in JPEG zigzag order.
module flow_zigzag #(
    parameter int N = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            in_valid_i,
    input  logic [N*16-1:0] in_data_i,
    input  logic            in_sob_i,
    input  logic            in_eob_i,
    input  logic            in_sof_i,
    output logic            out_valid_o,
    output logic [N*16-1:0] out_data_o,
    output logic            out_sob_o,
    output logic            out_eob_o,
    output logic            out_sof_o,
    output logic            err_o
);

    localparam int B  = 64 / N;
    localparam int CW = $clog2(B);
    localparam logic [CW-1:0] LAST = CW'(B - 1);

    // Zigzag position -> raster index of the 8x8 block.
    function automatic logic [5:0] zz(input logic [5:0] idx);
        logic [5:0] r;
        case (idx)
            6'd0:  r = 6'd0;  6'd1:  r = 6'd1;  6'd2:  r = 6'd8;  6'd3:  r = 6'd16;
            6'd4:  r = 6'd9;  6'd5:  r = 6'd2;  6'd6:  r = 6'd3;  6'd7:  r = 6'd10;
            6'd8:  r = 6'd17; 6'd9:  r = 6'd24; 6'd10: r = 6'd32; 6'd11: r = 6'd25;
            6'd12: r = 6'd18; 6'd13: r = 6'd11; 6'd14: r = 6'd4;  6'd15: r = 6'd5;
            6'd16: r = 6'd12; 6'd17: r = 6'd19; 6'd18: r = 6'd26; 6'd19: r = 6'd33;
            6'd20: r = 6'd40; 6'd21: r = 6'd48; 6'd22: r = 6'd41; 6'd23: r = 6'd34;
            6'd24: r = 6'd27; 6'd25: r = 6'd20; 6'd26: r = 6'd13; 6'd27: r = 6'd6;
            6'd28: r = 6'd7;  6'd29: r = 6'd14; 6'd30: r = 6'd21; 6'd31: r = 6'd28;
            6'd32: r = 6'd35; 6'd33: r = 6'd42; 6'd34: r = 6'd49; 6'd35: r = 6'd56;
            6'd36: r = 6'd57; 6'd37: r = 6'd50; 6'd38: r = 6'd43; 6'd39: r = 6'd36;
            6'd40: r = 6'd29; 6'd41: r = 6'd22; 6'd42: r = 6'd15; 6'd43: r = 6'd23;
            6'd44: r = 6'd30; 6'd45: r = 6'd37; 6'd46: r = 6'd44; 6'd47: r = 6'd51;
            6'd48: r = 6'd58; 6'd49: r = 6'd59; 6'd50: r = 6'd52; 6'd51: r = 6'd45;
            6'd52: r = 6'd38; 6'd53: r = 6'd31; 6'd54: r = 6'd39; 6'd55: r = 6'd46;
            6'd56: r = 6'd53; 6'd57: r = 6'd60; 6'd58: r = 6'd61; 6'd59: r = 6'd54;
            6'd60: r = 6'd47; 6'd61: r = 6'd55; 6'd62: r = 6'd62; 6'd63: r = 6'd63;
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    logic [15:0]     mem_q [2][64];
    logic [1:0]      full_q, full_d;
    logic [1:0]      sof_q, sof_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            wbank_q, wbank_d;
    logic            open_q, open_d;
    logic            rd_active_q, rd_active_d;
    logic            rbank_q, rbank_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic            out_valid_q, out_valid_d;
    logic [N*16-1:0] out_data_q, out_data_d;
    logic            out_sob_q, out_sob_d;
    logic            out_eob_q, out_eob_d;
    logic            out_sof_q, out_sof_d;
    logic            err_q, err_d;

    logic            we_s, commit_s, rd_clear_s, bank_busy_s;
    logic [CW-1:0]   wslot_s;
    logic [N*16-1:0] rd_data_s;

    // Reader sequencing: one zigzag beat per cycle, chaining straight into the other bank if it is full.
    always_comb begin
        rd_active_d = rd_active_q;
        rcnt_d      = rcnt_q;
        rbank_d     = rbank_q;
        rd_clear_s  = 1'b0;
        if (rd_active_q) begin
            if (rcnt_q == LAST) begin
                rd_clear_s  = 1'b1;
                rbank_d     = ~rbank_q;
                rcnt_d      = '0;
                rd_active_d = full_q[~rbank_q];
            end else begin
                rcnt_d = rcnt_q + CW'(1);
            end
        end else if (full_q[rbank_q]) begin
            rd_active_d = 1'b1;
            rcnt_d      = '0;
        end else begin
            rd_active_d = 1'b0;
        end
    end

    // Writer: framing checks, slot selection and bank commit. A bank being released this cycle counts as free.
    always_comb begin
        wcnt_d      = wcnt_q;
        wbank_d     = wbank_q;
        open_d      = open_q;
        sof_d       = sof_q;
        err_d       = 1'b0;
        we_s        = 1'b0;
        commit_s    = 1'b0;
        wslot_s     = in_sob_i ? '0 : wcnt_q;
        bank_busy_s = full_q[wbank_q] && !(rd_clear_s && (rbank_q == wbank_q));
        if (in_valid_i) begin
            if (!(in_sob_i || open_q)) begin
                err_d = 1'b1;
            end else if (bank_busy_s) begin
                err_d  = 1'b1;
                open_d = 1'b0;
                wcnt_d = '0;
            end else begin
                we_s = 1'b1;
                if (in_sob_i) begin
                    sof_d[wbank_q] = in_sof_i;
                end else begin
                    sof_d = sof_q;
                end
                if (wslot_s == LAST) begin
                    open_d = 1'b0;
                    wcnt_d = '0;
                    if (in_eob_i) begin
                        commit_s = 1'b1;
                        wbank_d  = ~wbank_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (in_eob_i) begin
                    open_d = 1'b0;
                    wcnt_d = '0;
                    err_d  = 1'b1;
                end else begin
                    open_d = 1'b1;
                    wcnt_d = wslot_s + CW'(1);
                end
            end
        end else begin
            err_d = 1'b0;
        end
    end

    // Full flags: reader release and writer commit never target the same bank in one cycle.
    always_comb begin
        full_d = full_q;
        if (rd_clear_s) begin
            full_d[rbank_q] = 1'b0;
        end else begin
            full_d = full_q;
        end
        if (commit_s) begin
            full_d[wbank_q] = 1'b1;
        end else begin
            full_d = full_d;
        end
    end

    // Zigzag read of the current bank and output beat framing.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < N; i++) begin
            rd_data_s[16*i +: 16] = mem_q[rbank_q][zz(6'(N * int'(rcnt_q) + i))];
        end
        out_valid_d = rd_active_q;
        if (rd_active_q) begin
            out_data_d = rd_data_s;
            out_sob_d  = (rcnt_q == '0);
            out_eob_d  = (rcnt_q == LAST);
            out_sof_d  = (rcnt_q == '0) && sof_q[rbank_q];
        end else begin
            out_data_d = '0;
            out_sob_d  = 1'b0;
            out_eob_d  = 1'b0;
            out_sof_d  = 1'b0;
        end
    end

    // Coefficient storage; contents need no reset since the full flags gate every read.
    always_ff @(posedge clk_i) begin
        if (rst_ni && en_i && we_s) begin
            for (int i = 0; i < N; i++) begin
                mem_q[wbank_q][6'(N * int'(wslot_s) + i)] <= in_data_i[16*i +: 16];
            end
        end
    end

    // Control and output registers with synchronous reset and global enable.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q      <= 2'b00;
            sof_q       <= 2'b00;
            wcnt_q      <= '0;
            wbank_q     <= 1'b0;
            open_q      <= 1'b0;
            rd_active_q <= 1'b0;
            rbank_q     <= 1'b0;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sob_q   <= 1'b0;
            out_eob_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            err_q       <= 1'b0;
        end else if (en_i) begin
            full_q      <= full_d;
            sof_q       <= sof_d;
            wcnt_q      <= wcnt_d;
            wbank_q     <= wbank_d;
            open_q      <= open_d;
            rd_active_q <= rd_active_d;
            rbank_q     <= rbank_d;
            rcnt_q      <= rcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sob_q   <= out_sob_d;
            out_eob_q   <= out_eob_d;
            out_sof_q   <= out_sof_d;
            err_q       <= err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sob_o   = out_sob_q;
    assign out_eob_o   = out_eob_q;
    assign out_sof_o   = out_sof_q;
    assign err_o       = err_q;

endmodule

// File: doc/flow_zigzag.md
# flow_zigzag

Block-reorder stage for the flow stream. Consumes 8x8 coefficient blocks in raster order, N coefficients per beat, with the same valid/sob/eob/sof framing and global `en` used by the other flow_math stages. Emits each block in JPEG zigzag order on an identical flow interface. Sits after the quantizer (flow_mult) and feeds the entropy coder; double-buffered so continuous back-to-back blocks stream through without gaps or stalls.

## Interface
- N, 2, coefficients per beat; legal values 1, 2, 4, 8; beats per block B = 64/N
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  global clock enable; when 0 every register, including outputs, holds
- in_valid  in  1  input beat present
- in_data  in  N x 16 signed  raster coefficients; lane i of beat b is raster index N*b+i
- in_sob / in_eob / in_sof  in  1 each  start of block / end of block / start of frame; meaningful only with in_valid
- out_valid  out  1  output beat present
- out_data  out  N x 16 signed  lane i of out beat b is zigzag position N*b+i, i.e. raster index ZZ[N*b+i]
- out_sob / out_eob / out_sof  out  1 each  framing for the output block
- err  out  1  one-cycle pulse on a framing violation

## Operation
- Storage: two banks of 64 x 16; each bank has a full flag and a stored sof bit.
- Writer: beat counter wcnt in 0..B-1, plus a write-bank pointer.
  - Beat with in_sob: wcnt := 0; the beat is written at slot 0; sof captured for the bank.
  - Without sob, beats go to slot wcnt and wcnt increments.
  - A beat with no block open (no sob since the last commit or drop) is discarded and pulses err.
  - Beat B-1 with in_eob=1: bank committed (full := 1); the pointer toggles.
  - Beat B-1 with in_eob=0, or in_eob on any other beat: block dropped, err pulses, no output for that block.
  - sob arriving mid-block silently restarts the block; no err.
  - Beat arriving while the target bank is full: discarded, err pulses. This cannot occur with legal framing.
- Reader: idle until a bank is full, then issues reads for slots ZZ[N*b+i], b = 0..B-1, on consecutive cycles.
  - Clears the bank's full flag after issuing the last read.
  - If the other bank is already full at that point, its first read issues on the next cycle; output stays back-to-back.
- ZZ table is the standard JPEG order: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- Output framing per block:
  - out_sob=1 on beat 0 only; out_eob=1 on beat B-1 only.
  - out_sof = stored sof, on beat 0 only.
  - All framing bits are 0 whenever out_valid=0.
- Data passes through unmodified; no arithmetic, no saturation.

## Timing
- Reset (rst_n=0 at an edge): out_valid, out_sob, out_eob, out_sof, err = 0; out_data = 0; both banks empty; wcnt = 0; no block open. Any blocks in flight are lost.
- Latency: the eob beat is accepted at edge k; out beat 0 (out_sob) is registered at edge k+2, then B consecutive beats follow.
- Edges are counted only while en=1. With en=0, outputs freeze, including a held out_valid=1; the monitor samples only when en=1.
- Bank reuse: a bank's last read issues before the writer can reach its slot 0 again. This holds for back-to-back input: B beats per block at minimum, against B read cycles plus 1.
- err is registered, one cycle after the offending beat's edge.

## Test plan
- Single block, N=2, raster value = index (0..63), sof=1, continuous valid:
  - first out beat exactly 2 cycles after the eob beat: lanes {0,1}, out_sob=1, out_sof=1
  - beat 1 = {8,16}; beat 2 = {9,2}; beat 31 = {62,63} with out_eob=1
  - 32 contiguous out_valid cycles; err never asserted.
- Four back-to-back blocks with value = index + 100*blk, sof only on the first:
  - 128 contiguous output beats, zero gaps
  - out_sof=1 only on block 0 beat 0; each block's data matches its own ZZ ordering.
- Random valid gaps (0-5 idle cycles between beats) plus random en=0 cycles: output content and framing identical to the first scenario; outputs hold while en=0.
- Block with eob on beat 20: err pulses once, that block produces no output; the next legal block outputs normally.
- sob at beat 10 mid-block, followed by a full 32-beat block: no err; only the restarted block is output.
- rst_n low for 1 cycle during output beat 15: all outputs 0 the next cycle, the rest of the block is never emitted, and a block sent after reset is output correctly.
